pcie_cpl_tx: RTL and testbench

PCIE_CPL_TX -- requirements
Module: pcie_cpl_tx

---
 rtl/pcie_cpl_tx.sv | 144 ++++++++++++++
 tb/tb_pcie_cpl_tx.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_cpl_tx.sv
// Completion TLP transmitter: captures one completion request and streams it
// as 16-bit words on the VC0 transmit port once completion credits allow.
module pcie_cpl_tx (
    input  logic        sys_clk_125,
    input  logic        rst,
    input  logic        cpl_req,
    input  logic        cpl_has_data,
    input  logic [2:0]  cpl_status,
    input  logic [15:0] cpl_req_id,
    input  logic [7:0]  cpl_tag,
    input  logic [6:0]  cpl_lower_addr,
    input  logic [11:0] cpl_byte_cnt,
    input  logic [31:0] cpl_data,
    input  logic [7:0]  bus_num,
    input  logic [4:0]  dev_num,
    input  logic [2:0]  func_num,
    output logic        cpl_ack,
    output logic        cpl_busy,
    output logic        cpl_done,
    output logic [15:0] cpl_sent_cnt,
    output logic        tx_req_vc0,
    input  logic        tx_rdy_vc0,
    output logic [15:0] tx_data_vc0,
    output logic        tx_st_vc0,
    output logic        tx_end_vc0,
    output logic        tx_nlfy_vc0,
    input  logic [8:0]  tx_ca_cplh_vc0,
    input  logic [12:0] tx_ca_cpld_vc0,
    input  logic        tx_ca_cpl_recheck_vc0
);

    typedef enum logic [1:0] {IDLE, CRED, REQ, SEND} state_t;

    state_t      state, state_nxt;
    logic [2:0]  idx;
    logic        has_data;
    logic [2:0]  status;
    logic [15:0] req_id;
    logic [7:0]  tag;
    logic [6:0]  lower_addr;
    logic [11:0] byte_cnt;
    logic [31:0] data;
    logic [15:0] cpl_id;
    logic [15:0] sent_cnt;
    logic        ack_q;
    logic        done_q;

    logic [2:0]  last_idx;
    logic        capture;
    logic        credit_ok;
    logic        accept_last;

    assign last_idx    = has_data ? 3'd7 : 3'd5;
    assign capture     = (state == IDLE) && cpl_req;
    assign credit_ok   = !tx_ca_cpl_recheck_vc0 && (tx_ca_cplh_vc0 != '0) &&
                         (!has_data || (tx_ca_cpld_vc0 != '0));
    assign accept_last = (state == SEND) && tx_rdy_vc0 && (idx == last_idx);

    always_ff @(posedge sys_clk_125 or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (cpl_req)     state_nxt = CRED;
            CRED: if (credit_ok)   state_nxt = REQ;
            REQ:  if (tx_rdy_vc0)  state_nxt = SEND;
            SEND: if (accept_last) state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_125 or posedge rst) begin
        if (rst) begin
            idx        <= '0;
            has_data   <= 1'b0;
            status     <= '0;
            req_id     <= '0;
            tag        <= '0;
            lower_addr <= '0;
            byte_cnt   <= '0;
            data       <= '0;
            cpl_id     <= '0;
            sent_cnt   <= '0;
            ack_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            ack_q  <= capture;
            done_q <= accept_last;
            if (capture) begin
                has_data   <= cpl_has_data;
                status     <= cpl_status;
                req_id     <= cpl_req_id;
                tag        <= cpl_tag;
                lower_addr <= cpl_lower_addr;
                byte_cnt   <= cpl_byte_cnt;
                data       <= cpl_data;
                cpl_id     <= {bus_num, dev_num, func_num};
            end
            if (state == REQ) begin
                idx <= '0;
            end else if ((state == SEND) && tx_rdy_vc0 && (idx != last_idx)) begin
                idx <= idx + 3'd1;
            end
            if (accept_last) begin
                sent_cnt <= sent_cnt + 16'd1;
            end
        end
    end

    // Transmit outputs are decoded from state/index/captured fields only.
    always_comb begin
        tx_req_vc0  = (state == REQ);
        cpl_busy    = (state != IDLE);
        tx_st_vc0   = 1'b0;
        tx_end_vc0  = 1'b0;
        tx_data_vc0 = '0;
        if (state == SEND) begin
            tx_st_vc0  = (idx == 3'd0);
            tx_end_vc0 = (idx == last_idx);
            case (idx)
                3'd0:    tx_data_vc0 = has_data ? 16'h4A00 : 16'h0A00;
                3'd1:    tx_data_vc0 = {15'd0, has_data};
                3'd2:    tx_data_vc0 = cpl_id;
                3'd3:    tx_data_vc0 = {status, 1'b0, byte_cnt};
                3'd4:    tx_data_vc0 = req_id;
                3'd5:    tx_data_vc0 = {tag, 1'b0, lower_addr};
                3'd6:    tx_data_vc0 = data[31:16];
                default: tx_data_vc0 = data[15:0];
            endcase
        end
    end

    assign cpl_ack      = ack_q;
    assign cpl_done     = done_q;
    assign cpl_sent_cnt = sent_cnt;
    assign tx_nlfy_vc0  = 1'b0;

endmodule

// File: tb/tb_pcie_cpl_tx.sv
// Directed bench for pcie_cpl_tx: hand-computed TLP words checked word by word.
module tb_pcie_cpl_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpl_req, cpl_has_data;
    logic [2:0]  cpl_status;
    logic [15:0] cpl_req_id;
    logic [7:0]  cpl_tag;
    logic [6:0]  cpl_lower_addr;
    logic [11:0] cpl_byte_cnt;
    logic [31:0] cpl_data;
    logic [7:0]  bus_num;
    logic [4:0]  dev_num;
    logic [2:0]  func_num;
    logic        cpl_ack, cpl_busy, cpl_done;
    logic [15:0] cpl_sent_cnt;
    logic        tx_req_vc0, tx_rdy_vc0, tx_st_vc0, tx_end_vc0, tx_nlfy_vc0;
    logic [15:0] tx_data_vc0;
    logic [8:0]  tx_ca_cplh_vc0;
    logic [12:0] tx_ca_cpld_vc0;
    logic        tx_ca_cpl_recheck_vc0;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_w [8];

    pcie_cpl_tx dut (
        .sys_clk_125(clk), .rst(rst),
        .cpl_req(cpl_req), .cpl_has_data(cpl_has_data), .cpl_status(cpl_status),
        .cpl_req_id(cpl_req_id), .cpl_tag(cpl_tag), .cpl_lower_addr(cpl_lower_addr),
        .cpl_byte_cnt(cpl_byte_cnt), .cpl_data(cpl_data),
        .bus_num(bus_num), .dev_num(dev_num), .func_num(func_num),
        .cpl_ack(cpl_ack), .cpl_busy(cpl_busy), .cpl_done(cpl_done),
        .cpl_sent_cnt(cpl_sent_cnt),
        .tx_req_vc0(tx_req_vc0), .tx_rdy_vc0(tx_rdy_vc0), .tx_data_vc0(tx_data_vc0),
        .tx_st_vc0(tx_st_vc0), .tx_end_vc0(tx_end_vc0), .tx_nlfy_vc0(tx_nlfy_vc0),
        .tx_ca_cplh_vc0(tx_ca_cplh_vc0), .tx_ca_cpld_vc0(tx_ca_cpld_vc0),
        .tx_ca_cpl_recheck_vc0(tx_ca_cpl_recheck_vc0)
    );

    always #4 clk = ~clk;

    initial begin
        #200000;
        $fatal(1, "FAIL watchdog: simulation did not complete");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic set_req(input logic hd, input logic [2:0] st, input logic [15:0] rid,
                           input logic [7:0] tg, input logic [6:0] la, input logic [11:0] bc,
                           input logic [31:0] d, input logic [7:0] b, input logic [4:0] dv,
                           input logic [2:0] fn);
        cpl_has_data = hd; cpl_status = st; cpl_req_id = rid; cpl_tag = tg;
        cpl_lower_addr = la; cpl_byte_cnt = bc; cpl_data = d;
        bus_num = b; dev_num = dv; func_num = fn;
    endtask

    task automatic set_words(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                             input logic [15:0] w3, input logic [15:0] w4, input logic [15:0] w5,
                             input logic [15:0] w6, input logic [15:0] w7);
        exp_w[0] = w0; exp_w[1] = w1; exp_w[2] = w2; exp_w[3] = w3;
        exp_w[4] = w4; exp_w[5] = w5; exp_w[6] = w6; exp_w[7] = w7;
    endtask

    task automatic issue(input logic keep);
        cpl_req = 1'b1;
        cyc();
        chk1("ack_pulse", cpl_ack, 1'b1);
        chk1("busy_set", cpl_busy, 1'b1);
        if (!keep) cpl_req = 1'b0;
        cyc();
        chk1("ack_single", cpl_ack, 1'b0);
        chk1("busy_hold", cpl_busy, 1'b1);
    endtask

    task automatic wait_req();
        int k = 0;
        while (tx_req_vc0 !== 1'b1 && k < 50) begin
            cyc();
            k++;
        end
        chk1("req_seen", tx_req_vc0, 1'b1);
    endtask

    task automatic run_tlp(input int n, input int stall_at, input int stall_len);
        wait_req();
        chk16("req_data_zero", tx_data_vc0, 16'h0000);
        chk1("req_st_zero", tx_st_vc0, 1'b0);
        cyc();
        chk1("req_hold", tx_req_vc0, 1'b1);
        tx_rdy_vc0 = 1'b1;
        cyc();
        for (int i = 0; i < n; i++) begin
            chk1("req_low", tx_req_vc0, 1'b0);
            chk16($sformatf("word%0d", i), tx_data_vc0, exp_w[i]);
            chk1($sformatf("st%0d", i), tx_st_vc0, i == 0);
            chk1($sformatf("end%0d", i), tx_end_vc0, i == n - 1);
            chk1("ack_in_send", cpl_ack, 1'b0);
            if (i == stall_at) begin
                tx_rdy_vc0 = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    cyc();
                    chk16("stall_word", tx_data_vc0, exp_w[i]);
                    chk1("stall_st", tx_st_vc0, i == 0);
                    chk1("stall_end", tx_end_vc0, i == n - 1);
                end
                tx_rdy_vc0 = 1'b1;
            end
            cyc();
        end
        chk1("done_pulse", cpl_done, 1'b1);
        chk1("busy_clear", cpl_busy, 1'b0);
        chk16("idle_data", tx_data_vc0, 16'h0000);
        chk1("idle_end", tx_end_vc0, 1'b0);
        chk1("idle_st", tx_st_vc0, 1'b0);
        tx_rdy_vc0 = 1'b0;
        cyc();
        chk1("done_single", cpl_done, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        cpl_req = 1'b0;
        set_req(1'b0, 3'd0, 16'h0, 8'h0, 7'h0, 12'h0, 32'h0, 8'h0, 5'h0, 3'h0);
        tx_rdy_vc0 = 1'b0;
        tx_ca_cplh_vc0 = 9'd8;
        tx_ca_cpld_vc0 = 13'd8;
        tx_ca_cpl_recheck_vc0 = 1'b0;

        cyc();
        chk1("rst_req", tx_req_vc0, 1'b0);
        chk1("rst_st", tx_st_vc0, 1'b0);
        chk1("rst_end", tx_end_vc0, 1'b0);
        chk16("rst_data", tx_data_vc0, 16'h0000);
        chk1("rst_ack", cpl_ack, 1'b0);
        chk1("rst_busy", cpl_busy, 1'b0);
        chk1("rst_done", cpl_done, 1'b0);
        chk16("rst_cnt", cpl_sent_cnt, 16'h0000);
        chk1("nlfy", tx_nlfy_vc0, 1'b0);
        rst = 1'b0;
        cyc();

        // Reset in the middle of a CplD at word index 4
        set_req(1'b1, 3'd0, 16'h0100, 8'h05, 7'h04, 12'h004, 32'hDEADBEEF, 8'h01, 5'h02, 3'h0);
        set_words(16'h4A00, 16'h0001, 16'h0110, 16'h0004, 16'h0100, 16'h0504, 16'hDEAD, 16'hBEEF);
        issue(1'b0);
        wait_req();
        tx_rdy_vc0 = 1'b1;
        cyc();
        for (int i = 0; i < 4; i++) begin
            chk16($sformatf("pre_rst_word%0d", i), tx_data_vc0, exp_w[i]);
            cyc();
        end
        chk16("pre_rst_word4", tx_data_vc0, 16'h0100);
        rst = 1'b1;
        #1;
        chk16("mid_rst_data", tx_data_vc0, 16'h0000);
        chk1("mid_rst_st", tx_st_vc0, 1'b0);
        chk1("mid_rst_end", tx_end_vc0, 1'b0);
        chk1("mid_rst_req", tx_req_vc0, 1'b0);
        chk1("mid_rst_busy", cpl_busy, 1'b0);
        chk1("mid_rst_done", cpl_done, 1'b0);
        chk16("mid_rst_cnt", cpl_sent_cnt, 16'h0000);
        cyc();
        rst = 1'b0;
        tx_rdy_vc0 = 1'b0;
        cyc();
        chk1("post_rst_done", cpl_done, 1'b0);
        chk1("post_rst_busy", cpl_busy, 1'b0);
        chk1("post_rst_req", tx_req_vc0, 1'b0);

        // CplD, ready one cycle after request
        issue(1'b0);
        run_tlp(8, -1, 0);
        chk16("cnt_after_cpld", cpl_sent_cnt, 16'h0001);

        // Cpl UR without data
        set_req(1'b0, 3'b001, 16'hABCD, 8'h7F, 7'h7F, 12'h000, 32'h0, 8'h12, 5'h1F, 3'h7);
        set_words(16'h0A00, 16'h0000, 16'h12FF, 16'h2000, 16'hABCD, 16'h7F7F, 16'h0, 16'h0);
        issue(1'b0);
        run_tlp(6, -1, 0);
        chk16("cnt_after_ur", cpl_sent_cnt, 16'h0002);

        // CplD CA with a 3-cycle stall on word 3
        set_req(1'b1, 3'b100, 16'h1234, 8'hA5, 7'h3C, 12'hFFF, 32'h01234567, 8'hFF, 5'h00, 3'h1);
        set_words(16'h4A00, 16'h0001, 16'hFF01, 16'h8FFF, 16'h1234, 16'hA53C, 16'h0123, 16'h4567);
        issue(1'b0);
        run_tlp(8, 3, 3);
        chk16("cnt_after_stall", cpl_sent_cnt, 16'h0003);

        // Header credit starvation, then recheck blocking
        tx_ca_cplh_vc0 = 9'd0;
        tx_ca_cpld_vc0 = 13'd0;
        set_req(1'b0, 3'd0, 16'h0002, 8'h00, 7'h00, 12'h010, 32'h0, 8'h00, 5'h00, 3'h0);
        set_words(16'h0A00, 16'h0000, 16'h0000, 16'h0010, 16'h0002, 16'h0000, 16'h0, 16'h0);
        issue(1'b0);
        for (int i = 0; i < 10; i++) begin
            chk1($sformatf("no_cplh_req%0d", i), tx_req_vc0, 1'b0);
            cyc();
        end
        tx_ca_cplh_vc0 = 9'd1;
        tx_ca_cpl_recheck_vc0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk1($sformatf("recheck_req%0d", i), tx_req_vc0, 1'b0);
        end
        tx_ca_cpl_recheck_vc0 = 1'b0;
        run_tlp(6, -1, 0);
        chk16("cnt_after_credit", cpl_sent_cnt, 16'h0004);
        tx_ca_cpld_vc0 = 13'd8;

        // Counter wrap with cpl_req held high across two requests
        force dut.sent_cnt = 16'hFFFF;
        cyc();
        release dut.sent_cnt;
        cyc();
        chk16("cnt_preset", cpl_sent_cnt, 16'hFFFF);
        set_req(1'b1, 3'd0, 16'h5555, 8'h11, 7'h22, 12'h008, 32'hCAFEF00D, 8'h03, 5'h04, 3'h5);
        set_words(16'h4A00, 16'h0001, 16'h0325, 16'h0008, 16'h5555, 16'h1122, 16'hCAFE, 16'hF00D);
        issue(1'b1);
        set_req(1'b0, 3'b100, 16'h9876, 8'h80, 7'h01, 12'hABC, 32'h0, 8'hAA, 5'h15, 3'h2);
        run_tlp(8, -1, 0);
        chk1("second_ack", cpl_ack, 1'b1);
        chk1("second_busy", cpl_busy, 1'b1);
        chk16("cnt_wrap", cpl_sent_cnt, 16'h0000);
        cpl_req = 1'b0;
        set_words(16'h0A00, 16'h0000, 16'hAAAA, 16'h8ABC, 16'h9876, 16'h8001, 16'h0, 16'h0);
        cyc();
        chk1("second_ack_single", cpl_ack, 1'b0);
        run_tlp(6, -1, 0);
        chk16("cnt_after_wrap", cpl_sent_cnt, 16'h0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
